// File: rtl/ram_bus_pkg.sv
// Shared types and default sizes for the RAM bus master and the RAM it talks to.
package ram_bus_pkg;

    localparam int DWIDTH_DEF   = 32;
    localparam int MEMDEPTH_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_TURN  = 3'd3,
        ST_RESP  = 3'd4,
        ST_VREAD = 3'd5,
        ST_VCHK  = 3'd6
    } state_e;

endpackage

// File: rtl/ram_bus_master.sv
// Single-word load/store initiator for the shared-bus RAM; optional write read-back
// check is enabled by defining WRITE_VERIFY_EN.
//
// state | meaning
// IDLE  | bus released, req_ready=1, waiting for a request
// WRITE | mem_wrEn=1, block drives mem_data with the store word
// READ  | mem_rdEn=1 for RD_LAT cycles, data captured on the last edge
// TURN  | bus idle after a read, load response strobe
// RESP  | store response strobe
// VREAD | read-back of the just-written word (WRITE_VERIFY_EN)
// VCHK  | store response with read-back compare result (WRITE_VERIFY_EN)
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int MEMDEPTH = MEMDEPTH_DEF,
    parameter int AWIDTH   = $clog2(MEMDEPTH),
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic              mem_rdEn,
    output logic              mem_wrEn,
    output logic [AWIDTH-1:0] mem_addr
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    state_e              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_we;
    logic                r_rsp_err;
    logic [DWIDTH-1:0]   r_rsp_rdata;
    logic                r_rd_en;
    logic                r_wr_en;
    logic                r_drive;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic [CW-1:0]       r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_drive     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        if (req_we) begin
                            r_state <= ST_WRITE;
                            r_wr_en <= 1'b1;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_rd_en <= 1'b1;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_drive <= 1'b0;
`ifdef WRITE_VERIFY_EN
                    // Bus is released on this edge, so the read-back can start right away.
                    r_state <= ST_VREAD;
                    r_rd_en <= 1'b1;
                    r_cnt   <= CNT_INIT;
`else
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_we    <= 1'b1;
                    r_rsp_err   <= 1'b0;
`endif
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_TURN;
                        r_rd_en     <= 1'b0;
                        r_rsp_rdata <= mem_data;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_TURN, ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
`ifdef WRITE_VERIFY_EN
                ST_VREAD: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_VCHK;
                        r_rd_en     <= 1'b0;
                        r_rsp_rdata <= mem_data;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b1;
                        r_rsp_err   <= (mem_data != r_wdata);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_VCHK: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_rd_en     <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_drive     <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data  = r_drive ? r_wdata : {DWIDTH{1'bz}};
    assign mem_rdEn  = r_rd_en;
    assign mem_wrEn  = r_wr_en;
    assign mem_addr  = r_addr;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;
`ifdef WRITE_VERIFY_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master with a behavioural RAM on the shared data bus.
module tb_ram_bus_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RD_LAT = 1;
`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int LAT_LD = RD_LAT + 1;
    localparam int LAT_ST = VERIFY ? RD_LAT + 2 : 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    wire  [DW-1:0] mem_data;
    logic          mem_rdEn;
    logic          mem_wrEn;
    logic [AW-1:0] mem_addr;

    ram_bus_master #(.DWIDTH(DW), .MEMDEPTH(256), .AWIDTH(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_data(mem_data), .mem_rdEn(mem_rdEn), .mem_wrEn(mem_wrEn), .mem_addr(mem_addr)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; stuck0 models a bit-0 stuck-at-0 cell array.
    logic [DW-1:0] ram [256];
    logic          stuck0 = 1'b0;
    always @(posedge clk) if (mem_wrEn) ram[mem_addr] <= mem_data & ~{{(DW-1){1'b0}}, stuck0};
    assign mem_data = mem_rdEn ? ram[mem_addr] : {DW{1'bz}};

    typedef struct {
        bit          we;
        logic [DW-1:0] rdata;
        bit          chk_rdata;
        bit          err;
        int          due;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    rsp_t          rsp_q[$];
    wr_t           wr_q[$];
    logic [DW-1:0] ref_mem [256];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            last_rd = -100;
    bit            prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus invariants, write beats and response scoreboard.
    always @(negedge clk) begin
        if (mem_wrEn || mem_rdEn)
            chk("one_enable", !(mem_wrEn && mem_rdEn), {mem_wrEn, mem_rdEn}, 2'b00);
        if (mem_wrEn) begin
            chk("wr_single_cycle", !prev_wr, prev_wr, 0);
            chk("rd_to_wr_gap", (cyc - last_rd) >= 2, cyc - last_rd, 2);
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 1'b0, mem_addr, 0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", mem_addr == w.addr, mem_addr, w.addr);
                chk("wr_data", mem_data == w.data, mem_data, w.data);
            end
        end
        if (mem_rdEn) last_rd = cyc;
        prev_wr = mem_wrEn;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1'b0, rsp_rdata, 0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_latency", cyc == e.due, cyc, e.due);
                chk("rsp_we", rsp_we == e.we, rsp_we, e.we);
                chk("rsp_err", rsp_err == e.err, rsp_err, e.err);
                if (e.chk_rdata) chk("rsp_rdata", rsp_rdata == e.rdata, rsp_rdata, e.rdata);
            end
        end
    end

    // Called at a negedge; holds req_valid until accepted, models the result.
    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit push, input bit hold);
        int n = 0;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", n < 50, n, 50);
        if (n < 50) begin
            if (we) wr_q.push_back('{addr: a, data: d});
            if (push) begin
                rsp_t e;
                if (we) begin
                    logic [DW-1:0] stored;
                    stored = d & ~{{(DW-1){1'b0}}, stuck0};
                    ref_mem[a] = stored;
                    e = '{we: 1'b1, rdata: stored, chk_rdata: VERIFY, err: VERIFY && (stored != d),
                          due: cyc + LAT_ST};
                end else begin
                    e = '{we: 1'b0, rdata: ref_mem[a], chk_rdata: 1'b1, err: 1'b0, due: cyc + LAT_LD};
                end
                rsp_q.push_back(e);
            end
            @(negedge clk);
            chk("ready_low_busy", req_ready == 1'b0, req_ready, 0);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
        chk("drain", rsp_q.size() == 0 && wr_q.size() == 0, rsp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid == 1'b0, rsp_valid, 0);
        chk("reset_enables", {mem_wrEn, mem_rdEn} == 2'b00, {mem_wrEn, mem_rdEn}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready == 1'b1, req_ready, 1);
        chk("reset_rdata", rsp_rdata == '0, rsp_rdata, 0);
        chk("reset_addr", mem_addr == '0, mem_addr, 0);

        issue(1'b1, 8'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(1'b1, 8'd1, 32'h11111111, 1'b1, 1'b0);
        issue(1'b0, 8'd0, '0, 1'b1, 1'b0);
        issue(1'b0, 8'd1, '0, 1'b1, 1'b0);
        issue(1'b0, 8'd1, '0, 1'b1, 1'b1);
        issue(1'b1, 8'd1, 32'hA5A5A5A5, 1'b1, 1'b1);
        issue(1'b0, 8'd1, '0, 1'b1, 1'b0);
        drain();

        for (int a = 2; a < 16; a++) issue(1'b1, AW'(a), DW'($urandom), 1'b1, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 60; i++) begin
            issue($urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom), 1'b1,
                  $urandom_range(0, 2) != 0);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

`ifdef WRITE_VERIFY_EN
        issue(1'b1, 8'd7, 32'h12345678, 1'b1, 1'b0);
        drain();
        stuck0 = 1'b1;
        issue(1'b1, 8'd9, 32'h00000001, 1'b1, 1'b0);
        drain();
        stuck0 = 1'b0;
        issue(1'b0, 8'd9, '0, 1'b1, 1'b0);
        drain();
`endif

        // Reset in the middle of a load: the transfer is dropped without a response.
        issue(1'b0, 8'd1, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midreset_rsp_valid", rsp_valid == 1'b0, rsp_valid, 0);
            chk("midreset_enables", {mem_wrEn, mem_rdEn} == 2'b00, {mem_wrEn, mem_rdEn}, 0);
        end
        chk("midreset_rdata", rsp_rdata == '0, rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", req_ready == 1'b1, req_ready, 1);
        repeat (4) @(negedge clk);
        issue(1'b0, 8'd1, '0, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
